// File: rtl/mult_div_pkg.sv
// Shared types and helpers for the sequential multiply/divide blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_div_pkg;

    localparam int DEF_WIDTH = 32;
    // Widest operand the helper functions handle.
    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Unsigned magnitude of a two's complement value whose sign bit is neg.
    // The caller zero-extends to MAX_WIDTH and truncates the result back,
    // so the most negative value maps to 2^(w-1) without loss.
    // The same helper also applies a sign to a magnitude.
    function automatic logic [MAX_WIDTH-1:0] abs_u(input logic [MAX_WIDTH-1:0] x,
                                                   input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step over a {rem, quo} register pair.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module div_step
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2*WIDTH-1:0] rq_in,
    input  logic [WIDTH-1:0]   dmag,
    output logic [2*WIDTH-1:0] rq_out
);

    logic [2*WIDTH-1:0] shifted;
    logic [WIDTH:0]     trial;

    // Shift in the next dividend bit, try a subtract, keep it if no borrow.
    // The partial remainder stays below |B| <= 2^(WIDTH-1), so after the
    // shift it still fits in WIDTH bits; bit WIDTH of trial is the borrow.
    always_comb begin
        shifted = {rq_in[2*WIDTH-2:0], 1'b0};
        trial   = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, dmag};
        rq_out  = shifted;
        if (!trial[WIDTH]) begin
            rq_out[2*WIDTH-1:WIDTH] = trial[WIDTH-1:0];
            rq_out[0]               = 1'b1;
        end
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: truncating quotient and remainder, flags for /0 and MIN/-1.
// Latency: WIDTH+1 enabled edges after the load edge (1 for divide by zero).
// Backpressure: en=0 freezes everything; load is ignored while busy.
module seq_signed_divider
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_FIX  = FIX;
    localparam logic [1:0] ST_DONE = DONE;

    localparam int               CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] rq;
    logic [2*WIDTH-1:0] rq_nxt;
    logic [WIDTH-1:0]   dmag;
    logic               sa;
    logic               sb;
    logic               dz_p;
    logic               ov_p;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic               start;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rq_in  (rq),
        .dmag   (dmag),
        .rq_out (rq_nxt)
    );

    // Operand magnitudes and signed fix-up of the finished quotient/remainder.
    // On divide by zero the quotient half still holds |A|, so re-signing it
    // with sA reproduces A for the remainder.
    always_comb begin
        abs_a = WIDTH'(abs_u(MAX_WIDTH'(A), A[WIDTH-1]));
        abs_b = WIDTH'(abs_u(MAX_WIDTH'(B), B[WIDTH-1]));
        start = en && load && (state == ST_IDLE || state == ST_DONE);
        if (dz_p) begin
            q_fix = '1;
            r_fix = WIDTH'(abs_u(MAX_WIDTH'(rq[WIDTH-1:0]), sa));
        end else begin
            q_fix = WIDTH'(abs_u(MAX_WIDTH'(rq[WIDTH-1:0]), sa ^ sb));
            r_fix = WIDTH'(abs_u(MAX_WIDTH'(rq[2*WIDTH-1:WIDTH]), sa));
        end
    end

    // FSM, step counter, operand capture and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rq          <= '0;
            dmag        <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            dz_p        <= 1'b0;
            ov_p        <= 1'b0;
            Q           <= '0;
            R           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (en) begin
            if (start) begin
                rq          <= {{WIDTH{1'b0}}, abs_a};
                dmag        <= abs_b;
                sa          <= A[WIDTH-1];
                sb          <= B[WIDTH-1];
                dz_p        <= (B == '0);
                ov_p        <= (A == MIN_VAL) && (B == '1);
                cnt         <= '0;
                busy        <= 1'b1;
                done        <= 1'b0;
                div_by_zero <= 1'b0;
                overflow    <= 1'b0;
                state       <= (B == '0) ? ST_FIX : ST_CALC;
            end else begin
                case (state)
                    ST_CALC: begin
                        rq  <= rq_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        Q           <= q_fix;
                        R           <= r_fix;
                        div_by_zero <= dz_p;
                        overflow    <= ov_p;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= ST_DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
module tb_seq_signed_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] ain = '0;
    logic [W-1:0] bin = '0;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic         overflow;

    int ncmp = 0;
    int nfail = 0;

    seq_signed_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .A           (ain),
        .B           (bin),
        .Q           (q),
        .R           (r),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int           lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Launch one operation and count posedges until done is seen at a negedge.
    // Optional stall window (en=0) and an extra load pulse while busy.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int stall_at, input int stall_len,
                          input int ld2_at, input logic [W-1:0] a2, input logic [W-1:0] b2,
                          output int n, output logic busy1, output logic done1);
        @(negedge clk);
        ain = a; bin = b; load = 1'b1;
        n = 0; busy1 = 1'b0; done1 = 1'b1;
        while (n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            load = (n == ld2_at);
            if (n == ld2_at) begin
                ain = a2; bin = b2;
            end
            if (n == stall_at) en = 1'b0;
            if (n == stall_at + stall_len) en = 1'b1;
            if (n == 1) begin
                busy1 = busy; done1 = done;
            end
            if (done) break;
        end
        en = 1'b1;
        load = 1'b0;
    endtask

    task automatic check_result(input string nm, input vec_t v, input int n,
                                input logic busy1, input logic done1);
        chk({nm, ".lat"},   W'(n), W'(v.lat));
        chk({nm, ".busy1"}, W'(busy1), W'(1));
        chk({nm, ".done1"}, W'(done1), W'(0));
        chk({nm, ".q"},     q, v.q);
        chk({nm, ".r"},     r, v.r);
        chk({nm, ".dz"},    W'(div_by_zero), W'(v.dz));
        chk({nm, ".ov"},    W'(overflow), W'(v.ov));
        chk({nm, ".busy"},  W'(busy), W'(0));
    endtask

    initial begin
        int   n;
        logic b1;
        logic d1;
        vec_t v;

        //          A             B             Q             R             dz    ov    latency
        vecs[0] = '{32'd384,      -32'sd32,     -32'sd12,     32'd0,        1'b0, 1'b0, W + 2};
        vecs[1] = '{32'd75,       32'd15,       32'd5,        32'd0,        1'b0, 1'b0, W + 2};
        vecs[2] = '{32'd13,       32'd20,       32'd0,        32'd13,       1'b0, 1'b0, W + 2};
        vecs[3] = '{-32'sd51,     -32'sd4,      32'd12,       -32'sd3,      1'b0, 1'b0, W + 2};
        vecs[4] = '{-32'sd7,      32'd2,        -32'sd3,      -32'sd1,      1'b0, 1'b0, W + 2};
        vecs[5] = '{32'd7,        -32'sd2,      -32'sd3,      32'd1,        1'b0, 1'b0, W + 2};
        vecs[6] = '{32'd1234,     32'd0,        32'hFFFFFFFF, 32'd1234,     1'b1, 1'b0, 2};
        vecs[7] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 1'b1, W + 2};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.q", q, '0);
        chk("rst.r", r, '0);
        chk("rst.busy", W'(busy), '0);
        chk("rst.done", W'(done), '0);
        chk("rst.dz", W'(div_by_zero), '0);
        chk("rst.ov", W'(overflow), '0);
        rst = 1'b0;

        // Directed vectors, each loaded straight from DONE of the previous one
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, 0, 0, 0, '0, '0, n, b1, d1);
            check_result($sformatf("vec%0d", i), vecs[i], n, b1, d1);
        end

        // Stall of 5 cycles mid-calculation
        v = vecs[0];
        v.lat = W + 2 + 5;
        run_op(v.a, v.b, 10, 5, 0, '0, '0, n, b1, d1);
        check_result("stall", v, n, b1, d1);

        // Load with new operands while busy is ignored
        v = vecs[1];
        run_op(v.a, v.b, 0, 0, 5, 32'd13, 32'd20, n, b1, d1);
        check_result("ldbusy", v, n, b1, d1);

        // Back-to-back from DONE: done drops, result after WIDTH+1 edges
        v = vecs[0];
        run_op(v.a, v.b, 0, 0, 0, '0, '0, n, b1, d1);
        check_result("b2b", v, n, b1, d1);

        // Reset 10 cycles after a load aborts it
        @(negedge clk);
        ain = 32'd13; bin = 32'd20; load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("pre_rst.busy", W'(busy), W'(1));
        rst = 1'b1;
        #1;
        chk("mrst.q", q, '0);
        chk("mrst.r", r, '0);
        chk("mrst.busy", W'(busy), '0);
        chk("mrst.done", W'(done), '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 4) @(posedge clk);
        @(negedge clk);
        chk("post_rst.busy", W'(busy), '0);
        chk("post_rst.done", W'(done), '0);
        chk("post_rst.q", q, '0);
        v = vecs[1];
        run_op(v.a, v.b, 0, 0, 0, '0, '0, n, b1, d1);
        check_result("after_rst", v, n, b1, d1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
